// File: rtl/onehot_dec_pkg.sv
// Shared types and constants for the one-hot grant decoder.
// Optional decode-error reporting in the top is enabled by ONEHOT_DECODE_ERR_EN.
package onehot_dec_pkg;

  localparam int DEF_N     = 4;
  localparam int DEF_HOLD  = 4;
  localparam int DEF_GAP   = 1;
  localparam int MAX_N     = 16;
  localparam int MAX_IDX_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  // Callers truncate the result to their own N; indices >= N fall off the top.
  function automatic logic [MAX_N-1:0] idx_to_onehot(input logic [MAX_IDX_W-1:0] idx);
    idx_to_onehot = MAX_N'(1) << idx;
  endfunction

endpackage

// File: rtl/dec_cycle_counter.sv
// Saturating cycle counter: clears on clr, counts while en, flags done on the
// last of MAX cycles (MAX=0 means done immediately).
module dec_cycle_counter #(
  parameter int MAX = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam int W = (MAX < 1) ? 1 : $clog2(MAX + 1);
  localparam logic [W-1:0] CNT_SAT = W'(MAX);
  localparam logic [W-1:0] DONE_AT = (MAX > 0) ? W'(MAX - 1) : '0;

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CNT_SAT)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (MAX == 0) ? 1'b1 : (cnt_q == DONE_AT);

endmodule

// File: rtl/onehot_grant_decoder.sv
// Turns an encoded index into a registered one-hot grant held until ack or
// hold timeout, followed by a guard gap. Define ONEHOT_DECODE_ERR_EN to get decode_err.
//
// Handshake: an index transfers on a rising clk edge where in_valid && in_ready;
// in_ready depends on state only and is high only in IDLE.
module onehot_grant_decoder
  import onehot_dec_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int IDX_W = $clog2(N),
  parameter int HOLD  = DEF_HOLD,
  parameter int GAP   = DEF_GAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] in_idx,
  output logic [N-1:0]     out_onehot,
  output logic             out_valid,
  input  logic             out_ack,
  output logic             timeout,
  output logic             busy,
`ifdef ONEHOT_DECODE_ERR_EN
  output logic             decode_err,
`endif
  output logic [1:0]       dbg_state
);

  state_e         state_q, state_d;
  logic [N-1:0]   onehot_q, onehot_d;
  logic           valid_q, valid_d;
  logic           timeout_q, timeout_d;
  logic           derr_q, derr_d;
  logic           hold_done, gap_done;
  logic           accept;
  logic           in_range;

  assign accept = in_valid && (state_q == ST_IDLE);

`ifdef ONEHOT_DECODE_ERR_EN
  assign in_range = (int'(in_idx) < N);
`else
  assign in_range = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    onehot_d  = onehot_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;
    derr_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!in_range) begin
            derr_d = 1'b1;
          end else begin
            // An unrepresentable index yields an all-zero but valid grant.
            state_d  = ST_GRANT;
            onehot_d = N'(idx_to_onehot(MAX_IDX_W'(in_idx)));
            valid_d  = 1'b1;
          end
        end
      end
      ST_GRANT: begin
        if (out_ack || hold_done) begin
          onehot_d  = '0;
          valid_d   = 1'b0;
          timeout_d = !out_ack;
          state_d   = (GAP > 0) ? ST_GAP : ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_done) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        onehot_d = '0;
        valid_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      onehot_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      derr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      onehot_q  <= onehot_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      derr_q    <= derr_d;
    end
  end

  dec_cycle_counter #(.MAX(HOLD)) u_hold_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_q != ST_GRANT),
    .en   (state_q == ST_GRANT),
    .done (hold_done)
  );

  dec_cycle_counter #(.MAX(GAP)) u_gap_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_q != ST_GAP),
    .en   (state_q == ST_GAP),
    .done (gap_done)
  );

  assign in_ready   = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign out_onehot = onehot_q;
  assign out_valid  = valid_q;
  assign timeout    = timeout_q;
  assign dbg_state  = state_q;
`ifdef ONEHOT_DECODE_ERR_EN
  assign decode_err = derr_q;
`else
  logic unused_derr;
  assign unused_derr = derr_q;
`endif

endmodule

// File: tb/tb_onehot_grant_decoder.sv
// Bench for onehot_grant_decoder: DUT A (N=4,HOLD=4,GAP=1) and DUT B (N=3,HOLD=4,GAP=0)
// checked every cycle against a grant/timer model, plus directed literal checks.
module tb_onehot_grant_decoder;

`ifdef ONEHOT_DECODE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct {
    bit gnt;
    int idx;
    int left;
    int gap_left;
    bit tmo;
    bit derr;
    bit acc;
  } mdl_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         n_checks = 0;
  int         n_errors = 0;

  logic       a_iv = 1'b0, a_ack = 1'b0;
  logic [1:0] a_idx = '0;
  logic       a_rdy, a_ov, a_to, a_busy;
  logic [3:0] a_oh;
  logic [1:0] a_st;

  logic       b_iv = 1'b0, b_ack = 1'b0;
  logic [1:0] b_idx = '0;
  logic       b_rdy, b_ov, b_to, b_busy;
  logic [2:0] b_oh;
  logic [1:0] b_st;
`ifdef ONEHOT_DECODE_ERR_EN
  logic       a_derr, b_derr;
`endif

  mdl_t       ma = '{default: 0};
  mdl_t       mb = '{default: 0};
  logic [3:0] exp_q[$];
  logic       a_ov_prev = 1'b0;

  always #5 clk = ~clk;

  onehot_grant_decoder #(.N(4), .HOLD(4), .GAP(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_rdy), .in_idx(a_idx),
    .out_onehot(a_oh), .out_valid(a_ov), .out_ack(a_ack), .timeout(a_to),
    .busy(a_busy),
`ifdef ONEHOT_DECODE_ERR_EN
    .decode_err(a_derr),
`endif
    .dbg_state(a_st)
  );

  onehot_grant_decoder #(.N(3), .HOLD(4), .GAP(0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_rdy), .in_idx(b_idx),
    .out_onehot(b_oh), .out_valid(b_ov), .out_ack(b_ack), .timeout(b_to),
    .busy(b_busy),
`ifdef ONEHOT_DECODE_ERR_EN
    .decode_err(b_derr),
`endif
    .dbg_state(b_st)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // A grant lasts at most `hold` cycles, ack ends it early, then `gap` idle cycles.
  function automatic mdl_t mdl_step(mdl_t m, bit v, int idx, bit ack, int n, int hold, int gap);
    mdl_t r = m;
    r.tmo = 0;
    r.derr = 0;
    r.acc = 0;
    if (m.gnt) begin
      if (ack) begin
        r.gnt = 0;
        r.gap_left = gap;
      end else if (m.left == 1) begin
        r.gnt = 0;
        r.gap_left = gap;
        r.tmo = 1;
      end else begin
        r.left = m.left - 1;
      end
    end else if (m.gap_left > 0) begin
      r.gap_left = m.gap_left - 1;
    end else if (v) begin
      if (idx >= n && ERR_EN) begin
        r.derr = 1;
      end else begin
        r.gnt = 1;
        r.idx = idx;
        r.left = hold;
        r.acc = 1;
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] exp_oh(mdl_t m, int n);
    return (m.gnt && m.idx < n) ? (32'd1 << m.idx) : 32'd0;
  endfunction

  function automatic logic exp_rdy(mdl_t m);
    return !m.gnt && (m.gap_left == 0);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ma = '{default: 0};
      mb = '{default: 0};
      exp_q.delete();
    end else begin
      ma = mdl_step(ma, a_iv, int'(a_idx), a_ack, 4, 4, 1);
      mb = mdl_step(mb, b_iv, int'(b_idx), b_ack, 3, 4, 0);
      if (ma.acc) exp_q.push_back(4'(ma.idx));
    end
  end

  always @(negedge clk) begin
    logic [3:0] e;
    chk("a_onehot", 32'(a_oh), exp_oh(ma, 4));
    chk("a_valid", 32'(a_ov), 32'(ma.gnt));
    chk("a_ready", 32'(a_rdy), 32'(exp_rdy(ma)));
    chk("a_busy", 32'(a_busy), 32'(!exp_rdy(ma)));
    chk("a_timeout", 32'(a_to), 32'(ma.tmo));
    chk("a_onehot_max1", 32'($countones(a_oh) <= 1), 32'd1);
    chk("b_onehot", 32'(b_oh), exp_oh(mb, 3));
    chk("b_valid", 32'(b_ov), 32'(mb.gnt));
    chk("b_ready", 32'(b_rdy), 32'(exp_rdy(mb)));
    chk("b_busy", 32'(b_busy), 32'(!exp_rdy(mb)));
    chk("b_timeout", 32'(b_to), 32'(mb.tmo));
`ifdef ONEHOT_DECODE_ERR_EN
    chk("a_decode_err", 32'(a_derr), 32'(ma.derr));
    chk("b_decode_err", 32'(b_derr), 32'(mb.derr));
`endif
    if (a_ov && !a_ov_prev) begin
      if (exp_q.size() == 0) begin
        chk("sb_a_unexpected_grant", 32'(a_oh), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("sb_a_grant", 32'(a_oh), 32'd1 << e);
      end
    end
    a_ov_prev = a_ov;
  end

  initial begin
    tick();
    tick();
    rst = 1'b0;
    chk("rst_onehot", 32'(a_oh), 32'd0);
    chk("rst_valid", 32'(a_ov), 32'd0);
    chk("rst_ready", 32'(a_rdy), 32'd1);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_timeout", 32'(a_to), 32'd0);
    tick();

    // Ack-released grant followed by one guard cycle.
    a_iv = 1'b1; a_idx = 2'b10;
    tick();
    a_iv = 1'b0;
    chk("t1_onehot", 32'(a_oh), 32'b0100);
    chk("t1_valid", 32'(a_ov), 32'd1);
    chk("t1_ready", 32'(a_rdy), 32'd0);
    tick();
    a_ack = 1'b1;
    tick();
    a_ack = 1'b0;
    chk("t1_rel_onehot", 32'(a_oh), 32'd0);
    chk("t1_rel_valid", 32'(a_ov), 32'd0);
    chk("t1_gap_ready", 32'(a_rdy), 32'd0);
    tick();
    chk("t1_idle_ready", 32'(a_rdy), 32'd1);

    // Never acked: four grant cycles then a timeout pulse.
    a_iv = 1'b1; a_idx = 2'b11;
    tick();
    a_iv = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t2_hold_onehot", 32'(a_oh), 32'b1000);
      chk("t2_hold_timeout", 32'(a_to), 32'd0);
      tick();
    end
    chk("t2_rel_onehot", 32'(a_oh), 32'd0);
    chk("t2_timeout", 32'(a_to), 32'd1);
    tick();
    chk("t2_timeout_end", 32'(a_to), 32'd0);
    tick();
    chk("t2_no_regrant", 32'(a_ov), 32'd0);
    chk("t2_ready", 32'(a_rdy), 32'd1);

    // Ack in the same cycle the hold expires: no timeout.
    a_iv = 1'b1; a_idx = 2'b01;
    tick();
    a_iv = 1'b0;
    tick(); tick(); tick();
    chk("t3_last_cycle", 32'(a_oh), 32'b0010);
    a_ack = 1'b1;
    tick();
    a_ack = 1'b0;
    chk("t3_valid", 32'(a_ov), 32'd0);
    chk("t3_no_timeout", 32'(a_to), 32'd0);
    tick(); tick();

    // Asynchronous reset in the middle of a grant.
    a_iv = 1'b1; a_idx = 2'b00;
    tick();
    a_iv = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    chk("t4_async_onehot", 32'(a_oh), 32'd0);
    chk("t4_async_valid", 32'(a_ov), 32'd0);
    chk("t4_async_busy", 32'(a_busy), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("t4_ready", 32'(a_rdy), 32'd1);

    // GAP=0, in_valid held: back-to-back grants 0 then 1.
    b_iv = 1'b1; b_idx = 2'd0;
    tick();
    b_idx = 2'd1;
    chk("t5_first", 32'(b_oh), 32'b001);
    b_ack = 1'b1;
    tick();
    b_ack = 1'b0;
    chk("t5_released", 32'(b_ov), 32'd0);
    chk("t5_ready", 32'(b_rdy), 32'd1);
    tick();
    b_iv = 1'b0;
    chk("t5_second", 32'(b_oh), 32'b010);
    b_ack = 1'b1;
    tick();
    b_ack = 1'b0;
    tick();

    // Out-of-range index on N=3.
    b_iv = 1'b1; b_idx = 2'b11;
    tick();
    b_iv = 1'b0;
`ifdef ONEHOT_DECODE_ERR_EN
    chk("t6_derr", 32'(b_derr), 32'd1);
    chk("t6_valid", 32'(b_ov), 32'd0);
    chk("t6_ready", 32'(b_rdy), 32'd1);
    tick();
    chk("t6_derr_end", 32'(b_derr), 32'd0);
`else
    for (int i = 0; i < 4; i++) begin
      chk("t6_valid", 32'(b_ov), 32'd1);
      chk("t6_onehot", 32'(b_oh), 32'd0);
      tick();
    end
    chk("t6_timeout", 32'(b_to), 32'd1);
    chk("t6_released", 32'(b_ov), 32'd0);
`endif
    tick();

    for (int c = 0; c < 600; c++) begin
      a_iv  = 1'($urandom_range(0, 1));
      a_idx = 2'($urandom_range(0, 3));
      a_ack = ($urandom_range(0, 3) == 0);
      b_iv  = 1'($urandom_range(0, 1));
      b_idx = 2'($urandom_range(0, 3));
      b_ack = ($urandom_range(0, 3) == 0);
      tick();
    end
    a_iv = 1'b0; b_iv = 1'b0; a_ack = 1'b1; b_ack = 1'b1;
    tick(); tick(); tick();
    chk("end_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
